rst_seq_ctrl: RTL and testbench

Reset sequencer that releases an ordered set of reset domains one at a time, with a programmable per-domain delay.
- Outputs are per-domain active-low reset enables. Each one drives the asynchronous reset input of a downstream clock/reset synchronizer interface instance, e.g. codec first, then DMA, then bus fabric.
- Sits in the always-on top-level clock domain.
- Also restarts the full sequence on a software reset request.

---
 rtl/rst_seq_pkg.sv | 14 +
 rtl/rst_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_rst_seq_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and default sizing for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } rst_seq_state_t;

  localparam int DEF_NUM_DOMAINS = 4;
  localparam int DEF_CNTR_W      = 8;
  localparam int DEF_HOLD_CYCLES = 16;

endpackage

// File: rtl/rst_seq_ctrl.sv
// Ordered reset release: hold every domain, then release them one at a time,
// each after its own programmable delay. A software request restarts the run.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int CNTR_W      = DEF_CNTR_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  localparam int IDX_W      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_sync,
  input  logic                          sw_rst_req,
  input  logic [NUM_DOMAINS*CNTR_W-1:0] cfg_dly,
  output logic [NUM_DOMAINS-1:0]        dom_rst_n,
  output logic [IDX_W-1:0]              seq_idx,
  output logic                          busy,
  output logic                          done
);

  localparam logic [CNTR_W-1:0] HOLD_LAST = CNTR_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

  rst_seq_state_t          state_q, state_d;
  logic [CNTR_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DOMAINS-1:0]  dom_q, dom_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    capture;
  logic [CNTR_W-1:0]       dly_q [NUM_DOMAINS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    capture = 1'b0;

    // A request wins over any release scheduled in the same cycle.
    if (sw_rst_req) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = WAIT;
            cnt_d   = '0;
            idx_d   = '0;
            capture = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == dly_q[idx_q]) begin
            dom_d[idx_q] = 1'b1;
            cnt_d        = '0;
            if (idx_q == LAST_IDX) begin
              state_d = RUN;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          dom_d = '1;
          idx_d = LAST_IDX;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          dom_d   = '0;
        end
      endcase
    end

    done_d = (state_d == RUN);
    busy_d = !done_d;
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Delays are frozen at the HOLD->WAIT transition for the whole sequence.
  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_shadow
    always_ff @(posedge clk) begin
      if (rst_sync) begin
        dly_q[gi] <= '0;
      end else if (capture) begin
        dly_q[gi] <= cfg_dly[gi*CNTR_W +: CNTR_W];
      end
    end
  end

  assign dom_rst_n = dom_q;
  assign seq_idx   = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: release-schedule model compared every cycle, plus
// literal release offsets for each directed scenario and a small-config instance.
module tb_rst_seq_ctrl;

  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 16;
  localparam logic [N*W-1:0] CFG_A = {8'd255, 8'd5, 8'd0, 8'd3};

  logic           clk = 1'b0;
  logic           rst_sync, sw_rst_req;
  logic [N*W-1:0] cfg_dly;
  logic [N-1:0]   dom_rst_n;
  logic [1:0]     seq_idx;
  logic           busy, done;

  logic           rst2;
  logic           sw2;
  logic [7:0]     cfg2;
  logic [3:0]     dom2;
  logic [1:0]     idx2;
  logic           busy2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rst_seq_ctrl #(.NUM_DOMAINS(N), .CNTR_W(W), .HOLD_CYCLES(H)) dut (
    .clk        (clk),
    .rst_sync   (rst_sync),
    .sw_rst_req (sw_rst_req),
    .cfg_dly    (cfg_dly),
    .dom_rst_n  (dom_rst_n),
    .seq_idx    (seq_idx),
    .busy       (busy),
    .done       (done)
  );

  rst_seq_ctrl #(.NUM_DOMAINS(4), .CNTR_W(2), .HOLD_CYCLES(1)) dut2 (
    .clk        (clk),
    .rst_sync   (rst2),
    .sw_rst_req (sw2),
    .cfg_dly    (cfg2),
    .dom_rst_n  (dom2),
    .seq_idx    (idx2),
    .busy       (busy2),
    .done       (done2)
  );

  // Model: a sequence starts counting on the edge after a reset/request edge;
  // domain k is released at start + H + sum(d[0..k]) + k.
  int edge_no  = 0;
  int start_e  = 0;
  int start2   = 0;
  bit cap_ok   = 0;
  int rel [N];
  int rise [N];
  int rise2 [4];
  logic [N-1:0] prev_dom = '0;
  logic [3:0]   prev_dom2 = '0;

  always @(posedge clk) begin
    int acc;
    edge_no++;
    if (rst_sync || sw_rst_req) begin
      start_e = edge_no + 1;
      cap_ok  = 0;
    end else if (!cap_ok && edge_no == start_e + H - 1) begin
      acc = start_e + H;
      for (int k = 0; k < N; k++) begin
        acc    = acc + int'(cfg_dly[k*W +: W]);
        rel[k] = acc + k;
      end
      cap_ok = 1;
    end
    if (rst2) start2 = edge_no + 1;
  end

  always @(negedge clk) begin
    int n;
    logic [N-1:0] exp_dom;
    logic [1:0]   exp_idx;
    logic         exp_done;
    if (edge_no > 0) begin
      n = 0;
      if (cap_ok)
        for (int k = 0; k < N; k++)
          if (edge_no >= rel[k]) n++;
      exp_dom  = N'((1 << n) - 1);
      exp_done = (n == N);
      exp_idx  = (n > N - 1) ? 2'(N - 1) : 2'(n);
      checks++;
      if (dom_rst_n !== exp_dom || seq_idx !== exp_idx ||
          done !== exp_done || busy !== !exp_done) begin
        errors++;
        $display("FAIL model edge=%0d got dom=%b idx=%0d busy=%b done=%b need dom=%b idx=%0d busy=%b done=%b",
                 edge_no - start_e, dom_rst_n, seq_idx, busy, done,
                 exp_dom, exp_idx, !exp_done, exp_done);
      end
      for (int k = 0; k < N; k++)
        if (dom_rst_n[k] && !prev_dom[k]) rise[k] = edge_no - start_e;
      for (int k = 0; k < 4; k++)
        if (dom2[k] && !prev_dom2[k]) rise2[k] = edge_no - start2;
      prev_dom  = dom_rst_n;
      prev_dom2 = dom2;
    end
  end

  task automatic chk(input string name, input int got, input int need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s got %0d need %0d", name, got, need);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_req();
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 600; i++) begin
      if (done) break;
      step();
    end
    if (!done) begin
      errors++;
      $display("FAIL %s timeout got done=%b need 1", name, done);
    end
  endtask

  task automatic wait_rise(input int k, input string name);
    int i;
    for (i = 0; i < 600; i++) begin
      if (dom_rst_n[k]) break;
      step();
    end
    if (!dom_rst_n[k]) begin
      errors++;
      $display("FAIL %s timeout got dom%0d=0 need 1", name, k);
    end
  endtask

  task automatic chk_rises(input string name, input int r0, input int r1,
                           input int r2, input int r3);
    chk({name, "_r0"}, rise[0], r0);
    chk({name, "_r1"}, rise[1], r1);
    chk({name, "_r2"}, rise[2], r2);
    chk({name, "_r3"}, rise[3], r3);
  endtask

  initial begin
    rst_sync   = 1'b1;
    sw_rst_req = 1'b0;
    cfg_dly    = CFG_A;
    rst2       = 1'b1;
    sw2        = 1'b0;
    cfg2       = 8'hFF;
    for (int k = 0; k < N; k++) rise[k] = -1;
    for (int k = 0; k < 4; k++) rise2[k] = -1;
    repeat (3) step();

    chk("reset_dom", int'(dom_rst_n), 0);
    chk("reset_busy", int'(busy), 1);
    chk("reset_done", int'(done), 0);
    chk("reset_idx", int'(seq_idx), 0);

    // Normal sequence, plus the HOLD_CYCLES=1 / CNTR_W=2 instance alongside.
    rst_sync = 1'b0;
    rst2     = 1'b0;
    wait_done("normal");
    chk_rises("normal", 19, 20, 26, 282);
    chk("normal_idx", int'(seq_idx), 3);
    chk("small_done", int'(done2), 1);
    chk("small_r0", rise2[0], 4);
    chk("small_r1", rise2[1], 8);
    chk("small_r2", rise2[2], 12);
    chk("small_r3", rise2[3], 16);

    // Restart from RUN.
    pulse_req();
    chk("restart_dom", int'(dom_rst_n), 0);
    chk("restart_done", int'(done), 0);
    chk("restart_busy", int'(busy), 1);
    wait_done("restart");
    chk_rises("restart", 19, 20, 26, 282);

    // Request lands on the edge that would release domain 2.
    pulse_req();
    wait_rise(1, "mid_wait");
    chk("mid_r1", rise[1], 20);
    repeat (5) step();
    pulse_req();
    chk("mid_dom", int'(dom_rst_n), 0);
    wait_done("mid_rerun");
    chk_rises("mid_rerun", 19, 20, 26, 282);

    // Config change after capture only affects the following sequence.
    pulse_req();
    wait_rise(0, "cfg_wait");
    cfg_dly = '0;
    wait_done("cfg_old");
    chk_rises("cfg_old", 19, 20, 26, 282);
    pulse_req();
    wait_done("cfg_new");
    chk_rises("cfg_new", 16, 17, 18, 19);

    // One-cycle rst_sync during WAIT.
    cfg_dly = CFG_A;
    pulse_req();
    wait_rise(1, "rst_wait");
    rst_sync = 1'b1;
    step();
    rst_sync = 1'b0;
    chk("rstw_dom", int'(dom_rst_n), 0);
    chk("rstw_busy", int'(busy), 1);
    chk("rstw_done", int'(done), 0);
    chk("rstw_idx", int'(seq_idx), 0);
    wait_done("rstw_rerun");
    chk_rises("rstw_rerun", 19, 20, 26, 282);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
